// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// The FETCH_PREFETCH_EN macro is consumed by instr_fetch_ctrl.sv.
package instr_fetch_ctrl_pkg;

    localparam int unsigned DefAddrW   = 8;
    localparam int unsigned DefDataW   = 16;
    localparam logic [3:0]  DefHaltOpc = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StValid,
        StHalted
    } state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2^WIDTH.
module pc_reg
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefAddrW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Next pc: explicit load wins, otherwise optional increment (natural wrap, no carry out).
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + WIDTH'(1);
        end
    end

    // pc register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives an external combinational ROM, registers the
// fetched instruction and hands it to decode over a valid/ready handshake.
// Optional macro FETCH_PREFETCH_EN: fetch the next instruction during the transfer
// cycle, giving one instruction per cycle.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW,
    parameter logic [3:0]  HALT_OPC = DefHaltOpc
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              rom_oeb,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted
);

`ifdef FETCH_PREFETCH_EN
    localparam bit Prefetch = 1'b1;
`else
    localparam bit Prefetch = 1'b0;
`endif

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              fetch_en;
    logic              xfer;
    logic              halt_pend;
    logic              capture;

    // A redirect discards the held instruction, so it suppresses the transfer.
    assign halt_pend = (instr_q[DATA_W-1 -: 4] == HALT_OPC);
    assign xfer      = (state_q == StValid) && instr_ready && !redirect;
    assign capture   = fetch_en && !redirect && ((state_q == StFetch) || xfer);

    pc_reg #(
        .WIDTH (ADDR_W)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (redirect),
        .load_addr (redirect_addr),
        .inc       (capture),
        .pc        (pc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                state_d = StValid;
            end
            StValid: begin
                if (xfer) begin
                    if (halt_pend) begin
                        state_d = StHalted;
                    end else if (run) begin
                        state_d = Prefetch ? StValid : StFetch;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: state_d = StIdle;
        endcase
        if (redirect) state_d = StFetch;
    end

    // Outputs decoded from state; the ROM is only enabled when its data is sampled.
    always_comb begin
        fetch_en    = (state_q == StFetch) ||
                      (Prefetch && (state_q == StValid) && run && !halt_pend);
        rom_oeb     = !fetch_en;
        rom_addr    = pc;
        instr_valid = (state_q == StValid);
        halted      = (state_q == StHalted);
    end

    // Instruction holding register; only loads on a fetch, so it is stable while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (capture) begin
            instr_q    <= rom_data;
            instr_pc_q <= pc;
        end
    end

    assign instr    = instr_q;
    assign instr_pc = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl (default build, no prefetch).
// Expected transfers are queued by the stimulus; a negedge monitor pops and compares.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        rom_oeb;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        halted;

    logic [15:0] rom [0:255];
    logic [23:0] exp_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_xfer = -1;
    bit spacing_on = 1'b0;

    instr_fetch_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .rom_oeb       (rom_oeb),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", {8'h0, instr_pc, instr}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("xfer_instr", 32'(instr), 32'(e[15:0]));
                check("xfer_instr_pc", 32'(instr_pc), 32'(e[23:16]));
            end
            if (spacing_on && last_xfer >= 0) check("xfer_spacing", cyc - last_xfer, 2);
            last_xfer = cyc;
        end
    end

    task automatic push(input logic [7:0] a);
        exp_q.push_back({a, rom[a]});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
        rom[0] = 16'h1001;
        rom[1] = 16'h2002;
        rom[2] = 16'h3003;
        rom[3] = 16'h4004;
        rom[5] = 16'hF000;

        rst = 1'b1;
        run = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_addr = 8'h00;
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_oeb", rom_oeb, 1);
        check("rst_addr", rom_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        tick();
        tick();

        // Straight-line fetch up to the halt opcode at address 5.
        for (int a = 0; a < 6; a++) push(8'(a));
        spacing_on = 1'b1;
        rst = 1'b0;
        run = 1'b1;
        instr_ready = 1'b1;
        for (int n = 0; n < 60 && !halted; n++) tick();
        check("halt_reached", halted, 1);
        spacing_on = 1'b0;
        check("halt_queue_empty", exp_q.size(), 0);
        tick();
        tick();
        check("halt_valid", instr_valid, 0);
        check("halt_oeb", rom_oeb, 1);
        check("halt_stays", halted, 1);

        // Redirect to 0 resumes fetch; then stall decode for 5 cycles.
        instr_ready = 1'b0;
        redirect = 1'b1;
        redirect_addr = 8'h00;
        tick();
        redirect = 1'b0;
        check("resume_halted_clear", halted, 0);
        for (int n = 0; n < 10 && !instr_valid; n++) tick();
        check("resume_valid", instr_valid, 1);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("stall_instr", instr, 16'h1001);
            check("stall_instr_pc", instr_pc, 8'h00);
            check("stall_pc", rom_addr, 8'h01);
            check("stall_oeb", rom_oeb, 1);
        end

        // Redirect while valid and ready: held instruction is dropped, 0x40 follows.
        push(8'h40);
        instr_ready = 1'b1;
        run = 1'b0;
        redirect = 1'b1;
        redirect_addr = 8'h40;
        tick();
        redirect = 1'b0;
        check("redir_valid_drop", instr_valid, 0);
        check("redir_fetch_addr", rom_addr, 8'h40);
        check("redir_fetch_oeb", rom_oeb, 0);
        drain("redir_drain");
        tick();
        tick();
        check("idle_valid", instr_valid, 0);
        check("idle_oeb", rom_oeb, 1);

        // pc wrap: fetch 0xFF then 0x00.
        push(8'hFF);
        push(8'h00);
        run = 1'b1;
        redirect = 1'b1;
        redirect_addr = 8'hFF;
        tick();
        redirect = 1'b0;
        drain("wrap_drain");
        instr_ready = 1'b0;
        for (int n = 0; n < 10 && !instr_valid; n++) tick();
        check("post_wrap_valid", instr_valid, 1);
        check("post_wrap_instr_pc", instr_pc, 8'h01);

        // Asynchronous reset mid-VALID takes effect before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_halted", halted, 0);
        check("arst_oeb", rom_oeb, 1);
        check("arst_addr", rom_addr, 0);
        check("arst_instr", instr, 0);
        check("arst_instr_pc", instr_pc, 0);
        tick();
        check("end_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, ROM address / program counter width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction width.
REQ-003 SHALL have parameter HALT_OPC, default 4'hF, opcode in instr[DATA_W-1:DATA_W-4] that halts fetch.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port run, input, 1, level; fetch is enabled while high.
REQ-007 SHALL have port rom_oeb, output, 1, active-low ROM output enable.
REQ-008 SHALL have port rom_addr, output, ADDR_W, ROM address (pc).
REQ-009 SHALL have port rom_data, input, DATA_W, combinational ROM instruction output.
REQ-010 SHALL have port instr, output, DATA_W, registered instruction to decode.
REQ-011 SHALL have port instr_pc, output, ADDR_W, address instr was fetched from.
REQ-012 SHALL have port instr_valid, output, 1, instr/instr_pc valid.
REQ-013 SHALL have port instr_ready, input, 1, decode accepts; transfer when valid and ready are both high.
REQ-014 SHALL have port redirect, input, 1, branch/jump request, single cycle.
REQ-015 SHALL have port redirect_addr, input, ADDR_W, branch/jump target.
REQ-016 SHALL have port halted, output, 1, high in HALTED state.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, VALID, HALTED.
REQ-018 IDLE: rom_oeb=1 and instr_valid=0; if run=1, go to FETCH next cycle.
REQ-019 FETCH: rom_oeb=0 and rom_addr=pc; at the edge, instr<=rom_data, instr_pc<=pc, pc<=pc+1, state<=VALID.
REQ-020 pc increment SHALL wrap modulo 2^ADDR_W (8'hFF -> 8'h00), with no flag.
REQ-021 VALID: instr_valid=1; instr and instr_pc SHALL be held stable until the transfer.
REQ-022 On a transfer, if instr opcode==HALT_OPC, go to HALTED; otherwise go to FETCH if run=1, else IDLE.
REQ-023 HALTED: rom_oeb=1, instr_valid=0, halted=1; exit only by redirect (to FETCH) or rst.
REQ-024 redirect SHALL have priority over the transfer, run and halt: pc<=redirect_addr, instr_valid cleared next cycle, state<=FETCH, and any pending instruction is discarded without a transfer.
REQ-025 Without the prefetch feature, latency from entering FETCH to instr_valid is 1 cycle, and peak throughput is 1 instruction per 2 cycles.
REQ-026 rom_oeb SHALL be high in every state that does not sample rom_data.

Reset
REQ-027 rst high SHALL asynchronously force state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, rom_oeb=1, rom_addr=0.
REQ-028 rst asserted mid-operation SHALL drop instr_valid immediately, and no transfer SHALL occur in that cycle.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN: when defined, in VALID with run=1 and no pending halt, rom_oeb=0 and rom_addr=pc; on a transfer, instr<=rom_data, instr_pc<=pc, pc<=pc+1 and state stays VALID, giving 1 instruction per cycle.
REQ-030 When FETCH_PREFETCH_EN is not defined, behaviour SHALL be exactly REQ-017..REQ-026.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/FETCH/VALID/HALTED), the default ADDR_W/DATA_W and HALT_OPC.
REQ-032 The pc register with increment/load/wrap SHALL be a separate sub-module, pc_reg.
REQ-033 The ROM is not instantiated inside the block; the top level connects it.

Verification
REQ-034 Reset then run=1, instr_ready=1, ROM[0..3]=16'h1001,16'h2002,16'h3003,16'h4004 -> instr sequence matches with instr_pc 0,1,2,3, one transfer per 2 cycles (per cycle with FETCH_PREFETCH_EN).
REQ-035 instr_ready=0 for 5 cycles while valid -> instr and instr_pc stable, pc unchanged, rom_oeb=1 (non-prefetch).
REQ-036 redirect=1 with redirect_addr=8'h40 while VALID and instr_ready=1 -> no transfer that cycle, next instr_pc=8'h40.
REQ-037 pc=8'hFF, run=1 -> instr_pc=8'hFF, then the next fetch is instr_pc=8'h00.
REQ-038 ROM[5]=16'hF000 -> after its transfer halted=1, instr_valid=0, rom_oeb=1; redirect to 8'h00 resumes fetch.
REQ-039 rst asserted asynchronously mid-VALID -> all outputs at reset values before the next clk edge.
